// File: rtl/sw_debounce_if.sv
// Switch conditioning bundle: raw levels in, debounced levels and
// change pulses out.
interface sw_debounce_if #(
  parameter int WIDTH = 10
);
  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_stable;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  logic             any_change;

  modport master (
    output sw_raw,
    input  sw_stable,
    input  sw_rise,
    input  sw_fall,
    input  any_change
  );

  modport slave (
    input  sw_raw,
    output sw_stable,
    output sw_rise,
    output sw_fall,
    output any_change
  );
endinterface

// File: rtl/sw_debounce.sv
// Per-bit switch synchroniser and debouncer with optional tick
// prescaler; registered levels and one-cycle rise/fall pulses.
module sw_debounce #(
  parameter int WIDTH         = 10,
  parameter int STABLE_CYCLES = 1000,
  parameter int TICK_DIV      = 1
) (
  input  logic          clk,
  input  logic          rst,
  sw_debounce_if.slave  io
);

  localparam int CW = (STABLE_CYCLES > 1) ?
                      $clog2(STABLE_CYCLES) : 1;
  localparam int PW = (TICK_DIV > 1) ?
                      $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] s0_q;
  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] stable_q;
  logic [WIDTH-1:0] stable_d;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] rise_d;
  logic [WIDTH-1:0] fall_q;
  logic [WIDTH-1:0] fall_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic             tick;

  generate
    if (TICK_DIV > 1) begin : g_div
      localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
      logic [PW-1:0] pdiv_q;
      logic [PW-1:0] pdiv_d;

      assign tick   = (pdiv_q == PMAX);
      assign pdiv_d = tick ? '0 : pdiv_q + PW'(1);

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) pdiv_q <= '0;
        else      pdiv_q <= pdiv_d;
      end
    end else begin : g_nodiv
      assign tick = 1'b1;
    end
  endgenerate

  // Any agreement with the accepted level restarts the count.
  always_comb begin
    stable_d = stable_q;
    rise_d   = '0;
    fall_d   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s1_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (tick) begin
        if (cnt_q[i] == CMAX) begin
          stable_d[i] = s1_q[i];
          cnt_d[i]    = '0;
          rise_d[i]   = s1_q[i];
          fall_d[i]   = ~s1_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s0_q     <= '0;
      s1_q     <= '0;
      stable_q <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s0_q     <= io.sw_raw;
      s1_q     <= s0_q;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign io.sw_stable  = stable_q;
  assign io.sw_rise    = rise_q;
  assign io.sw_fall    = fall_q;
  assign io.any_change = |(rise_q | fall_q);

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce: two sizings share one random/directed raw
// stream; a tick-counting model feeds per-instance scoreboards.
module tb_sw_debounce;

  localparam int W = 10;

  typedef struct {
    int           cyc;
    logic [W-1:0] st;
    logic [W-1:0] ri;
    logic [W-1:0] fa;
  } sb_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] raw = '0;
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < 2; g++) begin : u
      localparam int SC = (g == 0) ? 4 : 2;
      localparam int TD = (g == 0) ? 1 : 3;

      sw_debounce_if #(.WIDTH(W)) io();
      assign io.sw_raw = raw;

      sw_debounce #(
        .WIDTH(W),
        .STABLE_CYCLES(SC),
        .TICK_DIV(TD)
      ) dut (
        .clk(clk),
        .rst(rst),
        .io(io)
      );

      sb_t          q[$];
      int           n;
      logic [W-1:0] mst;
      logic [W-1:0] s0m;
      logic [W-1:0] s1m;
      int           rs [W];

      // Edge n is a tick when n is a multiple of TD; a run of
      // disagreement starting at edge b is accepted once it spans
      // SC ticks.
      always @(posedge clk or negedge rst) begin
        if (!rst) begin
          n   = 0;
          mst = '0;
          s0m = '0;
          s1m = '0;
          for (int i = 0; i < W; i++) rs[i] = 0;
          q.delete();
        end else begin
          logic [W-1:0] v;
          logic [W-1:0] ri;
          logic [W-1:0] fa;
          int           tk;
          n++;
          v   = s1m;
          s1m = s0m;
          s0m = raw;
          ri  = '0;
          fa  = '0;
          for (int i = 0; i < W; i++) begin
            if (v[i] == mst[i]) begin
              rs[i] = 0;
            end else begin
              if (rs[i] == 0) rs[i] = n;
              tk = n / TD - (rs[i] - 1) / TD;
              if (tk == SC) begin
                mst[i] = v[i];
                rs[i]  = 0;
                if (v[i]) ri[i] = 1'b1;
                else      fa[i] = 1'b1;
              end
            end
          end
          if ((ri | fa) != '0) begin
            sb_t e;
            e.cyc = n;
            e.st  = mst;
            e.ri  = ri;
            e.fa  = fa;
            q.push_back(e);
          end
        end
      end

      always @(negedge clk) begin
        if (rst) begin
          sb_t e;
          if (q.size() > 0 && q[0].cyc == n) begin
            e = q.pop_front();
          end else begin
            e.cyc = n;
            e.st  = mst;
            e.ri  = '0;
            e.fa  = '0;
          end
          checks++;
          if ({io.sw_stable, io.sw_rise, io.sw_fall, io.any_change}
              !== {e.st, e.ri, e.fa, |(e.ri | e.fa)}) begin
            errors++;
            $display("FAIL scoreboard[%0d] edge %0d: stable=%h rise=%h fall=%h any=%b, expected stable=%h rise=%h fall=%h any=%b",
                     g, n, io.sw_stable, io.sw_rise, io.sw_fall,
                     io.any_change, e.st, e.ri, e.fa,
                     |(e.ri | e.fa));
          end
        end
      end
    end
  endgenerate

  task automatic chk(string nm, logic [W-1:0] act,
                     logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [1:0] mux_f(logic [W-1:0] s);
    logic [1:0] y;
    y = s[1:0];
    return s[2 + 2 * y +: 2];
  endfunction

  task automatic hold(int c);
    repeat (c) @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] m;
    int           md;

    repeat (3) @(negedge clk);
    #1 rst = 1'b1;

    // reset behaviour
    @(negedge clk) raw = '1;
    hold(12);
    chk("pre_reset_stable", u[0].io.sw_stable, '1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_stable", u[0].io.sw_stable, '0);
    chk("async_pulse", u[0].io.sw_rise | u[0].io.sw_fall, '0);
    chk("async_any", W'(u[0].io.any_change), '0);
    @(negedge clk);
    #1 rst = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk("rst_edge5_stable", u[0].io.sw_stable, '0);
    @(posedge clk);
    #1;
    chk("rst_edge6_stable", u[0].io.sw_stable, '1);
    chk("rst_edge6_rise", u[0].io.sw_rise, '1);
    chk("rst_edge6_any", W'(u[0].io.any_change), W'(1));
    @(posedge clk);
    #1;
    chk("rst_edge7_rise", u[0].io.sw_rise, '0);
    chk("rst_edge7_any", W'(u[0].io.any_change), '0);

    // clean edge on bit 0
    @(negedge clk) raw = 10'h3FE;
    hold(12);
    raw = 10'h3FF;
    repeat (5) @(posedge clk);
    #1 chk("clean_k4_stable", u[0].io.sw_stable, 10'h3FE);
    @(posedge clk);
    #1;
    chk("clean_k5_stable", u[0].io.sw_stable, 10'h3FF);
    chk("clean_k5_rise", u[0].io.sw_rise, 10'h001);
    @(posedge clk);
    #1 chk("clean_k6_rise", u[0].io.sw_rise, '0);

    // bounce rejection on bit 3
    @(negedge clk) raw = '0;
    hold(12);
    for (int r = 0; r < 2; r++) begin
      raw[3] = 1'b1;
      hold(3);
      raw[3] = 1'b0;
      hold(3);
    end
    hold(6);
    chk("bounce_rejected", u[0].io.sw_stable, '0);
    raw[3] = 1'b1;
    hold(10);
    chk("bounce_accepted", u[0].io.sw_stable, 10'h008);

    // simultaneous fall on bit 1 and rise on bit 9
    raw = 10'h002;
    hold(12);
    raw = 10'h200;
    repeat (6) @(posedge clk);
    #1;
    chk("simul_rise", u[0].io.sw_rise, 10'h200);
    chk("simul_fall", u[0].io.sw_fall, 10'h002);
    chk("simul_any", W'(u[0].io.any_change), W'(1));

    // downstream mux select with bouncing inputs
    @(negedge clk);
    for (int r = 0; r < 6; r++) begin
      raw = 10'h392 ^ W'($urandom);
      hold(1);
      raw = 10'h392;
      hold($urandom_range(1, 2));
    end
    hold(12);
    chk("mux_f", W'(mux_f(u[0].io.sw_stable)), W'(2'b10));

    // randomized traffic, with one mid-run reset
    for (int it = 0; it < 400; it++) begin
      if (it == 200) begin
        @(posedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
      end
      md = $urandom_range(0, 2);
      m  = W'($urandom);
      if (md == 0) begin
        raw = raw ^ m;
        hold($urandom_range(1, 12));
      end else if (md == 1) begin
        raw = raw ^ m;
        hold($urandom_range(1, 3));
        raw = raw ^ m;
        hold($urandom_range(1, 4));
      end else begin
        hold($urandom_range(8, 15));
      end
    end
    hold(20);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
